// File: rtl/traffic_pkg.sv
// Shared encodings for the country-road traffic slice: detector states,
// light codes and controller state codes used by traffic_controller_unit.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        PRESENT = 3'd2,
        HOLD    = 3'd3
    } det_state_t;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } ctrl_state_t;

    localparam int STUCK_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous level inputs,
// cleared synchronously by the block-level clear.
module sync_2ff (
    input  logic clock,
    input  logic clear,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vehicle_presence_detector.sv
// Debounces the country-road loop detector into a clean vehicle level with
// gap bridging, arrival strobe/count and a sticky stuck-sensor flag.
module vehicle_presence_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 8,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             sensor_raw,
    input  logic             count_clear,
    output logic             vehicle,
    output logic             arrival_pulse,
    output logic [CNT_W-1:0] vehicle_count,
    output logic             stuck_fault
);

    localparam int QW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [QW-1:0]      QUAL_LAST   = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]      HOLD_LAST   = HW'(HOLD_CYCLES);
    localparam logic [STUCK_W-1:0] STUCK_LIMIT = STUCK_W'(STUCK_CYCLES);
    localparam logic [STUCK_W-1:0] STUCK_MAX   = '1;
    localparam logic [CNT_W-1:0]   COUNT_MAX   = '1;

    det_state_t         r_state;
    det_state_t         w_nextState;
    logic [QW-1:0]      r_qualCnt;
    logic [QW-1:0]      w_qualNext;
    logic [HW-1:0]      r_holdCnt;
    logic [HW-1:0]      w_holdNext;
    logic [STUCK_W-1:0] r_stuckCnt;
    logic [STUCK_W-1:0] w_stuckNext;
    logic               r_vehicle;
    logic               r_arrival;
    logic [CNT_W-1:0]   r_count;
    logic               r_stuckFault;
    logic               w_sensor;
    logic               w_arrival;

    sync_2ff u_sync (
        .clock (clock),
        .clear (clear),
        .i_d   (sensor_raw),
        .o_q   (w_sensor)
    );

    always_comb begin
        w_nextState = r_state;
        w_qualNext  = r_qualCnt;
        w_holdNext  = r_holdCnt;
        case (r_state)
            IDLE: begin
                w_qualNext = '0;
                w_holdNext = '0;
                if (w_sensor) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_nextState = PRESENT;
                    end else begin
                        w_nextState = QUALIFY;
                        w_qualNext  = QW'(1);
                    end
                end
            end
            QUALIFY: begin
                if (!w_sensor) begin
                    w_nextState = IDLE;
                    w_qualNext  = '0;
                end else if (r_qualCnt == QUAL_LAST) begin
                    w_nextState = PRESENT;
                    w_qualNext  = '0;
                end else begin
                    w_qualNext = r_qualCnt + QW'(1);
                end
            end
            PRESENT: begin
                w_holdNext = '0;
                if (!w_sensor) begin
                    if (HOLD_CYCLES == 0) begin
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = HOLD;
                        w_holdNext  = HW'(1);
                    end
                end
            end
            HOLD: begin
                // Sensor returning inside the hold window is the same vehicle.
                if (w_sensor) begin
                    w_nextState = PRESENT;
                    w_holdNext  = '0;
                end else if (r_holdCnt == HOLD_LAST) begin
                    w_nextState = IDLE;
                    w_holdNext  = '0;
                end else begin
                    w_holdNext = r_holdCnt + HW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_qualNext  = '0;
                w_holdNext  = '0;
            end
        endcase
    end

    assign w_arrival = (w_nextState == PRESENT) &&
                       ((r_state == IDLE) || (r_state == QUALIFY));

    always_comb begin
        w_stuckNext = '0;
        if ((r_state == PRESENT) && (w_nextState == PRESENT)) begin
            w_stuckNext = (r_stuckCnt == STUCK_MAX) ? r_stuckCnt : r_stuckCnt + STUCK_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state      <= IDLE;
            r_qualCnt    <= '0;
            r_holdCnt    <= '0;
            r_stuckCnt   <= '0;
            r_vehicle    <= 1'b0;
            r_arrival    <= 1'b0;
            r_count      <= '0;
            r_stuckFault <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_qualCnt  <= w_qualNext;
            r_holdCnt  <= w_holdNext;
            r_stuckCnt <= w_stuckNext;
            r_vehicle  <= (w_nextState == PRESENT) || (w_nextState == HOLD);
            r_arrival  <= w_arrival;
            // A clear coinciding with an arrival still counts that arrival.
            if (count_clear) begin
                r_count <= w_arrival ? CNT_W'(1) : '0;
            end else if (w_arrival && (r_count != COUNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_stuckNext == STUCK_LIMIT) begin
                r_stuckFault <= 1'b1;
            end
        end
    end

    assign vehicle       = r_vehicle;
    assign arrival_pulse = r_arrival;
    assign vehicle_count = r_count;
    assign stuck_fault   = r_stuckFault;

endmodule

// File: tb/tb_vehicle_presence_detector.sv
// Directed checks of the presence detector: dutA uses default parameters,
// dutB uses CNT_W=2 and STUCK_CYCLES=50 for saturation and stuck tests.
module tb_vehicle_presence_detector;

    logic       clock = 1'b0;
    logic       clearA = 1'b1;
    logic       sensorA = 1'b0;
    logic       countClearA = 1'b0;
    logic       vehicleA;
    logic       arrivalA;
    logic [7:0] countA;
    logic       faultA;

    logic       clearB = 1'b1;
    logic       sensorB = 1'b0;
    logic       countClearB = 1'b0;
    logic       vehicleB;
    logic       arrivalB;
    logic [1:0] countB;
    logic       faultB;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    vehicle_presence_detector dutA (
        .clock         (clock),
        .clear         (clearA),
        .sensor_raw    (sensorA),
        .count_clear   (countClearA),
        .vehicle       (vehicleA),
        .arrival_pulse (arrivalA),
        .vehicle_count (countA),
        .stuck_fault   (faultA)
    );

    vehicle_presence_detector #(.CNT_W(2), .STUCK_CYCLES(50)) dutB (
        .clock         (clock),
        .clear         (clearB),
        .sensor_raw    (sensorB),
        .count_clear   (countClearB),
        .vehicle       (vehicleB),
        .arrival_pulse (arrivalB),
        .vehicle_count (countB),
        .stuck_fault   (faultB)
    );

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int sawVehicle;
        int sawArrival;
        int pulses;
        int dropped;

        // Reset with sensor held high
        sensorA = 1'b1;
        applyStimulus(2);
        checkOutput("rst_vehicle", 32'(vehicleA), 0);
        checkOutput("rst_arrival", 32'(arrivalA), 0);
        checkOutput("rst_count", 32'(countA), 0);
        checkOutput("rst_fault", 32'(faultA), 0);
        checkOutput("rstB_count", 32'(countB), 0);
        clearA = 1'b0;
        clearB = 1'b0;
        applyStimulus(5);
        checkOutput("rise_edge5_vehicle", 32'(vehicleA), 0);
        applyStimulus(1);
        checkOutput("rise_edge6_vehicle", 32'(vehicleA), 1);
        checkOutput("rise_edge6_arrival", 32'(arrivalA), 1);
        checkOutput("rise_edge6_count", 32'(countA), 1);
        applyStimulus(1);
        checkOutput("rise_edge7_arrival", 32'(arrivalA), 0);
        sensorA = 1'b0;
        applyStimulus(10);
        checkOutput("fall_edge10_vehicle", 32'(vehicleA), 1);
        applyStimulus(1);
        checkOutput("fall_edge11_vehicle", 32'(vehicleA), 0);

        // count_clear on its own
        countClearA = 1'b1;
        applyStimulus(1);
        countClearA = 1'b0;
        checkOutput("cclr_count", 32'(countA), 0);

        // Glitch of 3 edges
        sawVehicle = 0;
        sawArrival = 0;
        sensorA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            if (vehicleA) sawVehicle++;
            if (arrivalA) sawArrival++;
        end
        sensorA = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            if (vehicleA) sawVehicle++;
            if (arrivalA) sawArrival++;
        end
        checkOutput("glitch_vehicle", 32'(sawVehicle), 0);
        checkOutput("glitch_arrival", 32'(sawArrival), 0);
        checkOutput("glitch_count", 32'(countA), 0);

        // Clean arrival, 20 edges high
        sensorA = 1'b1;
        applyStimulus(5);
        checkOutput("clean_edge5_vehicle", 32'(vehicleA), 0);
        applyStimulus(1);
        checkOutput("clean_edge6_vehicle", 32'(vehicleA), 1);
        checkOutput("clean_edge6_arrival", 32'(arrivalA), 1);
        checkOutput("clean_edge6_count", 32'(countA), 1);
        applyStimulus(1);
        checkOutput("clean_edge7_arrival", 32'(arrivalA), 0);
        applyStimulus(13);
        checkOutput("clean_edge20_vehicle", 32'(vehicleA), 1);
        sensorA = 1'b0;
        applyStimulus(10);
        checkOutput("clean_fall10_vehicle", 32'(vehicleA), 1);
        applyStimulus(1);
        checkOutput("clean_fall11_vehicle", 32'(vehicleA), 0);
        checkOutput("clean_final_count", 32'(countA), 1);

        // Gap bridging: high 10, low 5, high 10
        countClearA = 1'b1;
        applyStimulus(1);
        countClearA = 1'b0;
        checkOutput("gap_pre_count", 32'(countA), 0);
        pulses = 0;
        dropped = 0;
        for (int i = 1; i <= 25; i++) begin
            sensorA = !((i >= 11) && (i <= 15));
            applyStimulus(1);
            if (arrivalA) pulses++;
            if ((i >= 6) && !vehicleA) dropped++;
        end
        checkOutput("gap_dropped", 32'(dropped), 0);
        checkOutput("gap_pulses", 32'(pulses), 1);
        checkOutput("gap_count", 32'(countA), 1);
        sensorA = 1'b0;
        applyStimulus(10);
        checkOutput("gap_fall10_vehicle", 32'(vehicleA), 1);
        applyStimulus(1);
        checkOutput("gap_fall11_vehicle", 32'(vehicleA), 0);

        // Saturation on 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            sensorB = 1'b1;
            applyStimulus(8);
            sensorB = 1'b0;
            applyStimulus(14);
            checkOutput($sformatf("sat_count_%0d", k), 32'(countB), (k < 3) ? k : 3);
        end
        checkOutput("sat_vehicle_low", 32'(vehicleB), 0);

        // Sixth arrival with coincident count_clear, then held for stuck fault
        sensorB = 1'b1;
        applyStimulus(5);
        countClearB = 1'b1;
        applyStimulus(1);
        countClearB = 1'b0;
        checkOutput("cclr_arrival_count", 32'(countB), 1);
        checkOutput("cclr_arrival_pulse", 32'(arrivalB), 1);
        applyStimulus(49);
        checkOutput("stuck_edge55_fault", 32'(faultB), 0);
        applyStimulus(1);
        checkOutput("stuck_edge56_fault", 32'(faultB), 1);
        checkOutput("stuck_vehicle", 32'(vehicleB), 1);
        applyStimulus(20);
        checkOutput("stuck_sticky", 32'(faultB), 1);
        checkOutput("stuck_count", 32'(countB), 1);

        // Single clear pulse with sensor still high
        clearB = 1'b1;
        applyStimulus(1);
        clearB = 1'b0;
        checkOutput("midclr_fault", 32'(faultB), 0);
        checkOutput("midclr_vehicle", 32'(vehicleB), 0);
        checkOutput("midclr_count", 32'(countB), 0);
        applyStimulus(5);
        checkOutput("requal_edge5_vehicle", 32'(vehicleB), 0);
        applyStimulus(1);
        checkOutput("requal_edge6_vehicle", 32'(vehicleB), 1);
        checkOutput("requal_edge6_count", 32'(countB), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
